td4_prog_loader: RTL and testbench

Program memory and loader for the 4-bit CPU. Holds the 16×8 instruction store that the CPU reads through its `address`/`instr` fetch port. Accepts a new program as a byte stream over a valid/ready handshake, holding the CPU in reset while the store is rewritten. It sits between the host/programmer side and the CPU, and drives the CPU's active-low `n_reset`.

---
 rtl/td4_pkg.sv | 18 +
 rtl/td4_prog_ram.sv | 25 ++
 rtl/td4_prog_loader.sv | 146 ++++++++++++++
 tb/tb_td4_prog_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 program store and loader.
// Optional checksum feature is selected with TD4_PROG_CHECKSUM_EN.
package td4_pkg;

  localparam int TD4_ADDR_W  = 4;
  localparam int TD4_INSTR_W = 8;
  localparam logic [7:0] TD4_NOP = 8'h00;  // decodes as A <- A+0

  // CHECK and ERR are only reachable when TD4_PROG_CHECKSUM_EN is defined.
  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_RUN   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_CHECK = 3'd3,
    ST_ERR   = 3'd4
  } ld_state_t;

endpackage

// File: rtl/td4_prog_ram.sv
// 2^ADDR_W x DATA_W instruction store: one synchronous write port and one
// asynchronous read port. A write and a read of the same address in the
// same cycle returns the old data; the new data appears next cycle.
module td4_prog_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/td4_prog_loader.sv
// Program memory and loader for the TD4 CPU. Clears the store after reset,
// accepts a 16-byte program stream, and holds the CPU in reset while the
// store is not runnable. TD4_PROG_CHECKSUM_EN adds a 17th checksum byte
// (sum of all 17 bytes mod 256 must be 0) plus the CHECK/ERR states.
//
// Handshake: a byte transfers on a rising edge where ld_valid & ld_ready are
// both high. ld_ready is a registered state decode (high in LOAD/CHECK) and
// never depends on ld_valid; ld_valid may drop at any time to insert gaps.
module td4_prog_loader
  import td4_pkg::*;
#(
  parameter int ADDR_W  = TD4_ADDR_W,
  parameter int INSTR_W = TD4_INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  address,
  output logic [INSTR_W-1:0] instr,
  output logic               cpu_n_reset,
  input  logic               ld_start,
  input  logic               ld_valid,
  input  logic [INSTR_W-1:0] ld_data,
  output logic               ld_ready,
  output logic               busy,
  output logic               err,
  output ld_state_t          dbg_state
);

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  ld_state_t          state, state_nx;
  logic [ADDR_W-1:0]  ptr, ptr_nx;
  logic               we;
  logic [INSTR_W-1:0] wdata;

`ifdef TD4_PROG_CHECKSUM_EN
  logic [INSTR_W-1:0] sum, sum_nx, sum_add;
  assign sum_add = sum + ld_data;
`endif

  td4_prog_ram #(.ADDR_W(ADDR_W), .DATA_W(INSTR_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (ptr),
    .wdata (wdata),
    .raddr (address),
    .rdata (instr)
  );

  // Next-state, pointer/checksum update and memory write control.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    we       = 1'b0;
    wdata    = ld_data;
`ifdef TD4_PROG_CHECKSUM_EN
    sum_nx   = sum;
`endif
    case (state)
      ST_CLEAR: begin
        we     = 1'b1;
        wdata  = INSTR_W'(TD4_NOP);
        ptr_nx = ptr + ADDR_W'(1);
        if (ptr == PTR_LAST) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (ld_start) begin
          state_nx = ST_LOAD;
          ptr_nx   = '0;
`ifdef TD4_PROG_CHECKSUM_EN
          sum_nx   = '0;
`endif
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          we     = 1'b1;
          ptr_nx = ptr + ADDR_W'(1);
`ifdef TD4_PROG_CHECKSUM_EN
          sum_nx = sum_add;
          if (ptr == PTR_LAST) state_nx = ST_CHECK;
`else
          if (ptr == PTR_LAST) state_nx = ST_RUN;
`endif
        end
      end
`ifdef TD4_PROG_CHECKSUM_EN
      ST_CHECK: begin
        if (ld_valid) state_nx = (sum_add == '0) ? ST_RUN : ST_ERR;
      end
      ST_ERR: begin
        if (ld_start) begin
          state_nx = ST_LOAD;
          ptr_nx   = '0;
          sum_nx   = '0;
        end
      end
`endif
      default: state_nx = ST_CLEAR;
    endcase
  end

  // State, pointer and checksum registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_CLEAR;
      ptr   <= '0;
`ifdef TD4_PROG_CHECKSUM_EN
      sum   <= '0;
`endif
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
`ifdef TD4_PROG_CHECKSUM_EN
      sum   <= sum_nx;
`endif
    end
  end

  // Registered output decodes, aligned with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_n_reset <= 1'b0;
      ld_ready    <= 1'b0;
      busy        <= 1'b1;
    end else begin
      cpu_n_reset <= (state_nx == ST_RUN);
      ld_ready    <= (state_nx == ST_LOAD) || (state_nx == ST_CHECK);
      busy        <= (state_nx == ST_CLEAR) || (state_nx == ST_LOAD) ||
                     (state_nx == ST_CHECK);
    end
  end

`ifdef TD4_PROG_CHECKSUM_EN
  // Sticky checksum error flag: set on entry to ERR, cleared on reload.
  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else       err <= (state_nx == ST_ERR);
  end
`else
  assign err = 1'b0;
`endif

  assign dbg_state = state;

endmodule

// File: tb/tb_td4_prog_loader.sv
// Bench for td4_prog_loader: table-driven loads, hand-written corner cases
// and randomized loads checked against an array model of the store.
module tb_td4_prog_loader;
  import td4_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] address = '0;
  logic [7:0] instr;
  logic       cpu_n_reset;
  logic       ld_start = 1'b0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = '0;
  logic       ld_ready;
  logic       busy;
  logic       err;
  ld_state_t  dbg_state;

  td4_prog_loader dut (
    .clk(clk), .reset(reset), .address(address), .instr(instr),
    .cpu_n_reset(cpu_n_reset), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ld_ready), .busy(busy), .err(err),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

`ifdef TD4_PROG_CHECKSUM_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model and scoreboard.
  logic [7:0] model_mem [16];
  logic [7:0] prog [16];
  int         gap_cnt [17];
  int         spur_idx;
  bit         rand_start;
  bit         in_err = 1'b0;
  logic [7:0] exp_q [$];

  typedef struct {
    logic [7:0] base;
    logic [7:0] stride;
    int         gap_a;
    int         gap_b;
    int         gap_len;
    int         spur_at;
    logic [7:0] exp_last;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sweep all fetch addresses and compare against the model via exp_q.
  task automatic sweep(input string tag);
    logic [7:0] e;
    for (int a = 0; a < 16; a++) exp_q.push_back(model_mem[a]);
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1;
      e = exp_q.pop_front();
      chk(tag, instr, e);
      step();
    end
  endtask

  // Release-from-reset sequence: 16 CLEAR cycles, CPU runs in cycle 17.
  task automatic clear_phase(input bit poke_start);
    for (int c = 1; c <= 16; c++) begin
      chk("clear_nreset_low", cpu_n_reset, 0);
      chk("clear_busy", busy, 1);
      ld_start = (poke_start && c == 5);
      step();
      ld_start = 1'b0;
    end
    chk("run_nreset_c17", cpu_n_reset, 1);
    chk("run_busy_c17", busy, 0);
    chk("run_err_c17", err, 0);
    for (int a = 0; a < 16; a++) model_mem[a] = 8'h00;
    in_err = 1'b0;
  endtask

  // Full load of prog[], honouring gap_cnt[], spur_idx, rand_start.
  task automatic do_load(input int csum_byte);
    logic [7:0] sum, b;
    bit acc, exp_err;
    chk("pre_nreset", cpu_n_reset, in_err ? 0 : 1);
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    chk("start_nreset_low", cpu_n_reset, 0);
    chk("start_ready", ld_ready, 1);
    chk("start_err_clr", err, 0);
    sum = '0;
    exp_err = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (i < 16) b = prog[i];
      else b = (csum_byte < 0) ? 8'(-sum) : 8'(csum_byte);
      if (i < 16) sum = sum + b;
      else exp_err = ((sum + b) != 8'h00);
      chk("load_nreset_low", cpu_n_reset, 0);
      ld_valid = 1'b1;
      ld_data  = b;
      ld_start = (i == spur_idx);
      if (i < 16) address = 4'(i);
      acc = 1'b0;
      for (int w = 0; w < 20 && !acc; w++) begin
        if (ld_ready) begin
          if (i < 16) chk("old_on_write", instr, model_mem[i]);
          step();
          acc = 1'b1;
        end else step();
      end
      if (!acc) chk("accept_timeout", 0, 1);
      ld_valid = 1'b0;
      ld_start = 1'b0;
      if (i < 16) begin
        model_mem[i] = b;
        #1;
        chk("new_after_write", instr, b);
      end
      for (int g = 0; g < gap_cnt[i] && i < NB - 1; g++) begin
        chk("gap_ready", ld_ready, 1);
        chk("gap_nreset_low", cpu_n_reset, 0);
        ld_start = (rand_start && i < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
        ld_start = 1'b0;
      end
    end
    in_err = exp_err;
    chk("end_ready_low", ld_ready, 0);
    chk("end_nreset", cpu_n_reset, exp_err ? 0 : 1);
    chk("end_err", err, exp_err ? 1 : 0);
    chk("end_busy", busy, 0);
  endtask

  task automatic clear_gaps();
    for (int i = 0; i < 17; i++) gap_cnt[i] = 0;
    spur_idx = -1;
    rand_start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h10, 8'h01, 0, 0, 0, -1, 8'h1F};  // no stalls
    vecs[1] = '{8'h10, 8'h01, 4, 11, 3, -1, 8'h1F}; // gaps after bytes 4, 11
    vecs[2] = '{8'h10, 8'h01, 0, 0, 0, 5, 8'h1F};   // ld_start after 5 bytes
    vecs[3] = '{8'hA0, 8'h07, 2, 9, 1, -1, 8'h09};  // A0 + 15*7 mod 256

    // Reset values.
    step();
    step();
    chk("rst_nreset", cpu_n_reset, 0);
    chk("rst_ready", ld_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_err", err, 0);
    reset = 1'b0;
    clear_phase(1'b1);
    sweep("idle_zero");

    // Table-driven loads.
    foreach (vecs[v]) begin
      clear_gaps();
      if (vecs[v].gap_a > 0) gap_cnt[vecs[v].gap_a - 1] = vecs[v].gap_len;
      if (vecs[v].gap_b > 0) gap_cnt[vecs[v].gap_b - 1] = vecs[v].gap_len;
      spur_idx = vecs[v].spur_at;
      for (int i = 0; i < 16; i++) prog[i] = vecs[v].base + 8'(i) * vecs[v].stride;
      do_load(-1);
      address = 4'd15;
      #1;
      chk("vec_last_byte", instr, vecs[v].exp_last);
      step();
      sweep("vec_contents");
    end

    // Reset in the middle of a load, together with ld_start.
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'($urandom);
      step();
    end
    ld_valid = 1'b0;
    reset = 1'b1;
    ld_start = 1'b1;
    step();
    reset = 1'b0;
    ld_start = 1'b0;
    chk("midrst_ready", ld_ready, 0);
    clear_phase(1'b0);
    sweep("midrst_zero");

`ifdef TD4_PROG_CHECKSUM_EN
    // Checksum pass, fail, then recovery.
    clear_gaps();
    for (int i = 0; i < 16; i++) prog[i] = 8'h01;
    do_load(8'hF0);
    sweep("csum_ok");
    do_load(8'hF1);
    repeat (3) begin
      chk("err_hold", err, 1);
      chk("err_nreset_low", cpu_n_reset, 0);
      step();
    end
    do_load(-1);
    sweep("csum_recover");
`endif

    // Randomized loads with random gaps and ignored ld_start pulses.
    for (int r = 0; r < 6; r++) begin
      clear_gaps();
      rand_start = 1'b1;
      for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
      for (int i = 0; i < 17; i++) gap_cnt[i] = $urandom_range(0, 2);
      do_load(-1);
      sweep("rand_contents");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
